mips_exec_unit: RTL and testbench

- Execute-stage slice of the single-cycle 32-bit MIPS datapath: ALU-control decode, 32-bit ALU with carry/zero flags, and J/JAL jump-target formation.
- Sits between the register file and immediate mux on one side, and data memory, write-back mux and PC-update logic on the other.
- All results are available combinationally in the same cycle.
- A registered copy with 1-cycle latency is provided for pipelined or trace use.

---
 rtl/mips_exec_unit.sv | 151 +++++++++++++++
 tb/tb_mips_exec_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mips_exec_unit.sv
// mips_exec_unit: execute-stage slice of a single-cycle 32-bit MIPS
// datapath: ALU-control decode, 32-bit ALU with carry/zero, J/JAL target.
//
// Ports:
//   clock, reset_n    : system clock, async active-low reset
//   alu_op, funct     : main-control ALU class and instruction[5:0]
//   a, b, carry_in    : ALU operands and carry into ADD
//   pc_upper          : PC[31:28]
//   instr_index       : instruction[25:0]
//   in_valid          : qualifies capture into the output registers
//   alu_ctrl, result,
//   zero, carry_out,
//   jump_target       : combinational results
//   result_q, zero_q,
//   carry_q, jump_q,
//   valid_q           : registered copies, 1-cycle latency
module mips_exec_unit #(
    parameter bit WORD_ADDR = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    input  logic [3:0]  pc_upper,
    input  logic [25:0] instr_index,
    input  logic        in_valid,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry_out,
    output logic [31:0] jump_target,
    output logic [31:0] result_q,
    output logic        zero_q,
    output logic        carry_q,
    output logic [31:0] jump_q,
    output logic        valid_q
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    // ALU-control decode; unlisted funct codes (including jr) fall to ADD.
    always_comb begin
        alu_ctrl = OP_ADD;
        unique case (alu_op)
            2'b00: alu_ctrl = OP_ADD;
            2'b01: alu_ctrl = OP_SUB;
            2'b11: alu_ctrl = OP_OR;
            2'b10: begin
                case (funct)
                    6'b100000,
                    6'b100001: alu_ctrl = OP_ADD;
                    6'b100010,
                    6'b100011: alu_ctrl = OP_SUB;
                    6'b100100: alu_ctrl = OP_AND;
                    6'b100101: alu_ctrl = OP_OR;
                    6'b100110: alu_ctrl = OP_XOR;
                    6'b100111: alu_ctrl = OP_NOR;
                    6'b101010: alu_ctrl = OP_SLT;
                    6'b101011: alu_ctrl = OP_SLTU;
                    default:   alu_ctrl = OP_ADD;
                endcase
            end
            default: alu_ctrl = OP_ADD;
        endcase
    end

    logic [32:0] sum;

    always_comb begin
        sum       = 33'h0;
        result    = 32'h0;
        carry_out = 1'b0;
        unique case (alu_ctrl)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_ADD: begin
                sum       = {1'b0, a} + {1'b0, b} + {32'h0, carry_in};
                result    = sum[31:0];
                carry_out = sum[32];
            end
            // Carry out of a + ~b + 1 is the "no borrow" indication.
            OP_SUB: begin
                sum       = {1'b0, a} + {1'b0, ~b} + 33'd1;
                result    = sum[31:0];
                carry_out = sum[32];
            end
            OP_SLT:  result = {31'h0, $signed(a) < $signed(b)};
            OP_SLTU: result = {31'h0, a < b};
            default: result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);

    generate
        if (WORD_ADDR) begin : g_word
            assign jump_target = {pc_upper, 2'b00, instr_index};
        end else begin : g_byte
            assign jump_target = {pc_upper, instr_index, 2'b00};
        end
    endgenerate

    logic [31:0] result_d;
    logic        zero_d;
    logic        carry_d;
    logic [31:0] jump_d;
    logic        valid_d;

    always_comb begin
        valid_d  = in_valid;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        jump_d   = jump_q;
        if (in_valid) begin
            result_d = result;
            zero_d   = zero;
            carry_d  = carry_out;
            jump_d   = jump_target;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= 32'h0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            jump_q   <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            jump_q   <= jump_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_mips_exec_unit.sv
// tb_mips_exec_unit: directed self-checking bench for mips_exec_unit.
// Two instances cover both WORD_ADDR settings.
module tb_mips_exec_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic        carry_in;
    logic [3:0]  pc_upper;
    logic [25:0] instr_index;
    logic        in_valid;

    logic [2:0]  alu_ctrl, alu_ctrl_b;
    logic [31:0] result, result_b;
    logic        zero, zero_b;
    logic        carry_out, carry_out_b;
    logic [31:0] jump_target, jump_target_b;
    logic [31:0] result_q, result_q_b;
    logic        zero_q, zero_q_b;
    logic        carry_q, carry_q_b;
    logic [31:0] jump_q, jump_q_b;
    logic        valid_q, valid_q_b;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mips_exec_unit #(.WORD_ADDR(1'b1)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .alu_op(alu_op), .funct(funct),
        .a(a), .b(b), .carry_in(carry_in),
        .pc_upper(pc_upper), .instr_index(instr_index),
        .in_valid(in_valid),
        .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
        .carry_out(carry_out), .jump_target(jump_target),
        .result_q(result_q), .zero_q(zero_q), .carry_q(carry_q),
        .jump_q(jump_q), .valid_q(valid_q)
    );

    mips_exec_unit #(.WORD_ADDR(1'b0)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .alu_op(alu_op), .funct(funct),
        .a(a), .b(b), .carry_in(carry_in),
        .pc_upper(pc_upper), .instr_index(instr_index),
        .in_valid(in_valid),
        .alu_ctrl(alu_ctrl_b), .result(result_b), .zero(zero_b),
        .carry_out(carry_out_b), .jump_target(jump_target_b),
        .result_q(result_q_b), .zero_q(zero_q_b), .carry_q(carry_q_b),
        .jump_q(jump_q_b), .valid_q(valid_q_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic alu(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic ci);
        alu_op = op; funct = fn; a = va; b = vb; carry_in = ci;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0;
        alu_op = 2'b00; funct = 6'h0; a = 32'h0; b = 32'h0;
        carry_in = 1'b0; pc_upper = 4'h0; instr_index = 26'h0;
        #2;
        chk("rst_result_q", result_q, 32'h0);
        chk("rst_zero_q", {31'h0, zero_q}, 32'h0);
        chk("rst_carry_q", {31'h0, carry_q}, 32'h0);
        chk("rst_jump_q", jump_q, 32'h0);
        chk("rst_valid_q", {31'h0, valid_q}, 32'h0);

        alu(2'b00, 6'h0, 32'd2, 32'd3, 1'b0);
        chk("comb_in_reset", result, 32'd5);

        alu(2'b10, 6'b100010, 32'h0, 32'h0, 1'b0);
        chk("dec_sub", {29'h0, alu_ctrl}, 32'h6);
        alu(2'b10, 6'b101010, 32'h0, 32'h0, 1'b0);
        chk("dec_slt", {29'h0, alu_ctrl}, 32'h7);
        alu(2'b10, 6'b111111, 32'h0, 32'h0, 1'b0);
        chk("dec_other", {29'h0, alu_ctrl}, 32'h2);
        alu(2'b11, 6'b100111, 32'h0, 32'h0, 1'b0);
        chk("dec_ori", {29'h0, alu_ctrl}, 32'h1);
        alu(2'b10, 6'b101011, 32'h0, 32'h0, 1'b0);
        chk("dec_sltu", {29'h0, alu_ctrl}, 32'h5);

        alu(2'b00, 6'h0, 32'hFFFFFFFF, 32'h1, 1'b0);
        chk("add_wrap_res", result, 32'h0);
        chk("add_wrap_zero", {31'h0, zero}, 32'h1);
        chk("add_wrap_cy", {31'h0, carry_out}, 32'h1);
        alu(2'b00, 6'h0, 32'd5, 32'd7, 1'b1);
        chk("add_cin_res", result, 32'h0000000D);
        chk("add_cin_cy", {31'h0, carry_out}, 32'h0);

        alu(2'b01, 6'h0, 32'h0000ABCD, 32'h0000ABCD, 1'b1);
        chk("sub_eq_res", result, 32'h0);
        chk("sub_eq_zero", {31'h0, zero}, 32'h1);
        chk("sub_eq_cy", {31'h0, carry_out}, 32'h1);
        alu(2'b01, 6'h0, 32'd3, 32'd5, 1'b0);
        chk("sub_neg_res", result, 32'hFFFFFFFE);
        chk("sub_neg_zero", {31'h0, zero}, 32'h0);
        chk("sub_neg_cy", {31'h0, carry_out}, 32'h0);

        alu(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 1'b0);
        chk("slt", result, 32'h1);
        alu(2'b10, 6'b101011, 32'hFFFFFFFF, 32'h1, 1'b0);
        chk("sltu", result, 32'h0);
        chk("sltu_zero", {31'h0, zero}, 32'h1);
        alu(2'b10, 6'b100111, 32'h0, 32'h0, 1'b0);
        chk("nor", result, 32'hFFFFFFFF);
        alu(2'b10, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
        chk("xor", result, 32'h0FF00FF0);
        alu(2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
        chk("and", result, 32'hF000F000);
        alu(2'b11, 6'h0, 32'h12340000, 32'h00005678, 1'b0);
        chk("ori", result, 32'h12345678);

        pc_upper = 4'hA; instr_index = 26'h0000010;
        #1;
        chk("jump_word", jump_target, 32'hA0000010);
        chk("jump_byte", jump_target_b, 32'hA0000040);

        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 1'b1;
        alu_op = 2'b00; a = 32'd2; b = 32'd3; carry_in = 1'b0;
        @(posedge clock); #1;
        chk("reg_result_q", result_q, 32'd5);
        chk("reg_valid_q", {31'h0, valid_q}, 32'h1);
        chk("reg_zero_q", {31'h0, zero_q}, 32'h0);
        chk("reg_jump_q", jump_q, 32'hA0000010);
        chk("reg_jump_q_b", jump_q_b, 32'hA0000040);

        @(negedge clock);
        in_valid = 1'b0;
        a = 32'hFFFFFFFF; b = 32'h1;
        @(posedge clock); #1;
        chk("hold_result_q", result_q, 32'd5);
        chk("hold_valid_q", {31'h0, valid_q}, 32'h0);
        chk("hold_carry_q", {31'h0, carry_q}, 32'h0);

        @(negedge clock);
        in_valid = 1'b1;
        @(posedge clock); #1;
        chk("cap_zero_q", {31'h0, zero_q}, 32'h1);
        chk("cap_carry_q", {31'h0, carry_q}, 32'h1);

        #2;
        reset_n = 1'b0;
        #1;
        chk("async_result_q", result_q, 32'h0);
        chk("async_valid_q", {31'h0, valid_q}, 32'h0);
        chk("async_jump_q", jump_q, 32'h0);
        chk("async_carry_q", {31'h0, carry_q}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
